// File: rtl/intersection_phase_seq.sv
// Two-axis intersection phase sequencer: times each phase in tick strobes and
// drives light codes, transit flags and an enable strobe to the per-direction
// decoders. Optional EW skip on an empty sensor is built when SENSOR_SKIP_EN
// is defined (adds the senzor_ew_i input).
module intersection_phase_seq #(
  parameter int unsigned T_GREEN  = 5,
  parameter int unsigned T_YELLOW = 2,
  parameter int unsigned T_ALLRED = 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tick_i,
  input  logic       mode_noapte_i,
`ifdef SENSOR_SKIP_EN
  input  logic       senzor_ew_i,
`endif
  output logic [1:0] w_ns_o,
  output logic [1:0] w_ew_o,
  output logic       tranzit_ns_o,
  output logic       tranzit_ew_o,
  output logic       enable_o,
  output logic [2:0] phase_o
);

  localparam logic [2:0] S_INIT_RED  = 3'd0;
  localparam logic [2:0] S_NS_GREEN  = 3'd1;
  localparam logic [2:0] S_NS_YELLOW = 3'd2;
  localparam logic [2:0] S_CLR_1     = 3'd3;
  localparam logic [2:0] S_EW_GREEN  = 3'd4;
  localparam logic [2:0] S_EW_YELLOW = 3'd5;
  localparam logic [2:0] S_CLR_2     = 3'd6;
  localparam logic [2:0] S_NIGHT     = 3'd7;

  localparam logic [7:0] GREEN_LAST  = 8'(T_GREEN - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(T_YELLOW - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(T_ALLRED - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       enable_q;
  logic [7:0] cnt_last;
  logic       expire;
  logic       skip_ew;

`ifdef SENSOR_SKIP_EN
  assign skip_ew = ~senzor_ew_i;
`else
  assign skip_ew = 1'b0;
`endif

  always_comb begin
    cnt_last = ALLRED_LAST;
    case (state_q)
      S_NS_GREEN, S_EW_GREEN:   cnt_last = GREEN_LAST;
      S_NS_YELLOW, S_EW_YELLOW: cnt_last = YELLOW_LAST;
      default:                  cnt_last = ALLRED_LAST;
    endcase
  end

  assign expire = (cnt_q == cnt_last);

  // Everything advances only on tick; a green is cut short by a night request,
  // a yellow always runs to completion, clearance decides where to go next.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick_i) begin
      cnt_d = cnt_q + 8'd1;
      case (state_q)
        S_NS_GREEN: begin
          if (mode_noapte_i || expire) begin
            state_d = S_NS_YELLOW;
            cnt_d   = 8'd0;
          end
        end
        S_EW_GREEN: begin
          if (mode_noapte_i || expire) begin
            state_d = S_EW_YELLOW;
            cnt_d   = 8'd0;
          end
        end
        S_NS_YELLOW: begin
          if (expire) begin
            state_d = S_CLR_1;
            cnt_d   = 8'd0;
          end
        end
        S_EW_YELLOW: begin
          if (expire) begin
            state_d = S_CLR_2;
            cnt_d   = 8'd0;
          end
        end
        S_CLR_1: begin
          if (expire) begin
            cnt_d = 8'd0;
            if (mode_noapte_i)  state_d = S_NIGHT;
            else if (skip_ew)   state_d = S_NS_GREEN;
            else                state_d = S_EW_GREEN;
          end
        end
        S_INIT_RED, S_CLR_2: begin
          if (expire) begin
            cnt_d   = 8'd0;
            state_d = mode_noapte_i ? S_NIGHT : S_NS_GREEN;
          end
        end
        default: begin
          cnt_d = 8'd0;
          if (!mode_noapte_i) state_d = S_INIT_RED;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_INIT_RED;
      cnt_q    <= 8'd0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      enable_q <= tick_i;
    end
  end

  always_comb begin
    w_ns_o       = 2'b11;
    w_ew_o       = 2'b11;
    tranzit_ns_o = 1'b0;
    tranzit_ew_o = 1'b0;
    case (state_q)
      S_NS_GREEN:  begin w_ns_o = 2'b10; w_ew_o = 2'b00; end
      S_NS_YELLOW: begin w_ns_o = 2'b01; w_ew_o = 2'b00; end
      S_EW_GREEN:  begin w_ns_o = 2'b00; w_ew_o = 2'b10; end
      S_EW_YELLOW: begin w_ns_o = 2'b00; w_ew_o = 2'b01; end
      S_NIGHT:     begin tranzit_ns_o = 1'b1; tranzit_ew_o = 1'b1; end
      default:     begin w_ns_o = 2'b11; w_ew_o = 2'b11; end
    endcase
  end

  assign enable_o = enable_q;
  assign phase_o  = state_q;

endmodule

// File: tb/tb_intersection_phase_seq.sv
// Bench for intersection_phase_seq: a default instance and an all-ones timing
// instance share stimulus; expected outputs are queued per tick and popped on enable_o.
module tb_intersection_phase_seq;

  logic clk_i = 1'b0;
  logic rst_n_i;
  logic tick_i;
  logic mode_noapte_i;
  logic senzor_ew_i;

  logic [1:0] w_ns_a, w_ew_a, w_ns_b, w_ew_b;
  logic       tr_ns_a, tr_ew_a, tr_ns_b, tr_ew_b;
  logic       enable_a, enable_b;
  logic [2:0] phase_a, phase_b;
  logic [8:0] act_a, act_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  int         due_q[$];

  int m_phase[2];
  int m_elapsed[2];
  int m_g[2] = '{5, 1};
  int m_y[2] = '{2, 1};
  int m_a[2] = '{1, 1};

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  intersection_phase_seq u_dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .tick_i        (tick_i),
    .mode_noapte_i (mode_noapte_i),
`ifdef SENSOR_SKIP_EN
    .senzor_ew_i   (senzor_ew_i),
`endif
    .w_ns_o        (w_ns_a),
    .w_ew_o        (w_ew_a),
    .tranzit_ns_o  (tr_ns_a),
    .tranzit_ew_o  (tr_ew_a),
    .enable_o      (enable_a),
    .phase_o       (phase_a)
  );

  intersection_phase_seq #(.T_GREEN(1), .T_YELLOW(1), .T_ALLRED(1)) u_fast (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .tick_i        (tick_i),
    .mode_noapte_i (mode_noapte_i),
`ifdef SENSOR_SKIP_EN
    .senzor_ew_i   (senzor_ew_i),
`endif
    .w_ns_o        (w_ns_b),
    .w_ew_o        (w_ew_b),
    .tranzit_ns_o  (tr_ns_b),
    .tranzit_ew_o  (tr_ew_b),
    .enable_o      (enable_b),
    .phase_o       (phase_b)
  );

  assign act_a = {phase_a, w_ns_a, w_ew_a, tr_ns_a, tr_ew_a};
  assign act_b = {phase_b, w_ns_b, w_ew_b, tr_ns_b, tr_ew_b};

  // Light codes straight from the phase table: {phase, ns, ew, tr_ns, tr_ew}.
  function automatic logic [8:0] exp_vec(input int p);
    logic [1:0] ns, ew;
    logic       tr;
    ns = 2'b11;
    ew = 2'b11;
    tr = (p == 7);
    case (p)
      1: begin ns = 2'b10; ew = 2'b00; end
      2: begin ns = 2'b01; ew = 2'b00; end
      4: begin ns = 2'b00; ew = 2'b10; end
      5: begin ns = 2'b00; ew = 2'b01; end
      default: begin ns = 2'b11; ew = 2'b11; end
    endcase
    return {3'(p), ns, ew, tr, tr};
  endfunction

  task automatic check_vec(input string name, input logic [8:0] act, input logic [8:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got phase=%0d ns=%b ew=%b tr=%b%b, want phase=%0d ns=%b ew=%b tr=%b%b",
               name, act[8:6], act[5:4], act[3:2], act[1], act[0],
               expv[8:6], expv[5:4], expv[3:2], expv[1], expv[0]);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %b, want %b", name, act, expv);
    end
  endtask

  task automatic check_phase(input string name, input logic [2:0] act, input int expv);
    checks++;
    if (act !== 3'(expv)) begin
      failures++;
      $display("FAIL %s: got phase %0d, want %0d", name, act, expv);
    end
  endtask

  // Phase k lasts its duration in ticks; greens abort on night, clearances divert to night.
  task automatic model_tick(input int k);
    int  p, d, nxt;
    logic skip;
`ifdef SENSOR_SKIP_EN
    skip = !senzor_ew_i;
`else
    skip = 1'b0;
`endif
    p = m_phase[k];
    d = (p == 1 || p == 4) ? m_g[k] : (p == 2 || p == 5) ? m_y[k] : m_a[k];
    if (p == 7) begin
      m_elapsed[k] = 0;
      if (!mode_noapte_i) m_phase[k] = 0;
    end else begin
      m_elapsed[k] = m_elapsed[k] + 1;
      if (((p == 1) || (p == 4)) && mode_noapte_i) begin
        m_phase[k] = p + 1;
        m_elapsed[k] = 0;
      end else if (m_elapsed[k] == d) begin
        case (p)
          1, 4:    nxt = p + 1;
          2:       nxt = 3;
          5:       nxt = 6;
          3:       nxt = mode_noapte_i ? 7 : (skip ? 1 : 4);
          default: nxt = mode_noapte_i ? 7 : 1;
        endcase
        m_phase[k] = nxt;
        m_elapsed[k] = 0;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0;
      m_elapsed[k] = 0;
    end
  endtask

  // Called on a negedge; each high cycle of tick_i is one tick.
  task automatic tick_pulse(input int hold, input int gap);
    for (int i = 0; i < hold; i++) begin
      tick_i = 1'b1;
      model_tick(0);
      model_tick(1);
      exp_q0.push_back(exp_vec(m_phase[0]));
      exp_q1.push_back(exp_vec(m_phase[1]));
      due_q.push_back(cyc + 1);
      @(negedge clk_i);
    end
    tick_i = 1'b0;
    repeat (gap) @(negedge clk_i);
  endtask

  task automatic check_now(input string name);
    check_vec({name, "_std"}, act_a, exp_vec(m_phase[0]));
    check_vec({name, "_fast"}, act_b, exp_vec(m_phase[1]));
  endtask

  // Called on a negedge right after a tick, so enable_o is high when reset hits.
  task automatic async_reset(input string name);
    #2;
    check_bit({name, "_enable_before"}, enable_a, 1'b1);
    rst_n_i = 1'b0;
    #1;
    check_vec({name, "_std"}, act_a, 9'b000_11_11_00);
    check_vec({name, "_fast"}, act_b, 9'b000_11_11_00);
    check_bit({name, "_enable"}, enable_a, 1'b0);
    exp_q0.delete();
    exp_q1.delete();
    due_q.delete();
    model_reset();
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // Monitor: enable_o is the valid; every pulse must match the oldest queued tick.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      check_bit("enable_match", enable_b, enable_a);
      if (enable_a) begin
        checks++;
        if (due_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_enable: got enable_o=1 at cycle %0d, want 0", cyc);
        end else begin
          if (due_q[0] != cyc) begin
            failures++;
            $display("FAIL enable_timing: got pulse at cycle %0d, want %0d", cyc, due_q[0]);
          end
          check_vec("tick_std", act_a, exp_q0.pop_front());
          check_vec("tick_fast", act_b, exp_q1.pop_front());
          void'(due_q.pop_front());
        end
      end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_enable: got enable_o=0 at cycle %0d, want 1", cyc);
        void'(due_q.pop_front());
        void'(exp_q0.pop_front());
        void'(exp_q1.pop_front());
      end
    end
  end

  int seq_exp[17] = '{1, 1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 4, 5, 5, 6, 1};

  initial begin
    rst_n_i       = 1'b0;
    tick_i        = 1'b0;
    mode_noapte_i = 1'b0;
    senzor_ew_i   = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_i);
    check_vec("reset_std", act_a, 9'b000_11_11_00);
    check_vec("reset_fast", act_b, 9'b000_11_11_00);
    check_bit("reset_enable", enable_a, 1'b0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Full normal cycle, one tick every 4 clocks.
    for (int t = 0; t < 17; t++) begin
      tick_pulse(1, 3);
      check_phase($sformatf("cycle_std_t%0d", t + 1), phase_a, seq_exp[t]);
      check_phase($sformatf("cycle_fast_t%0d", t + 1), phase_b, 1 + (t % 6));
    end

    // Night request on the 2nd tick of NS_GREEN.
    tick_pulse(1, 2);
    mode_noapte_i = 1'b1;
    tick_pulse(1, 2);
    check_phase("night_to_yellow", phase_a, 2);
    tick_pulse(1, 2);
    check_phase("night_yellow_holds", phase_a, 2);
    tick_pulse(1, 2);
    check_phase("night_clr", phase_a, 3);
    tick_pulse(1, 2);
    check_phase("night_entered", phase_a, 7);
    check_bit("night_tranzit_ns", tr_ns_a, 1'b1);
    check_bit("night_tranzit_ew", tr_ew_a, 1'b1);
    tick_pulse(3, 2);
    check_phase("night_stays", phase_a, 7);
    mode_noapte_i = 1'b0;
    tick_pulse(1, 2);
    check_phase("night_exit_init", phase_a, 0);
    tick_pulse(1, 2);
    check_phase("night_exit_green", phase_a, 1);

    // Walk into EW_GREEN (two ticks in), then reset asynchronously.
    for (int t = 0; t < 9; t++) tick_pulse(1, 1);
    tick_pulse(1, 0);
    check_phase("pre_reset_ewgreen", phase_a, 4);
    async_reset("mid_reset");
    tick_pulse(1, 2);
    check_phase("restart_green", phase_a, 1);
    check_now("restart");

    // No ticks for 100 clocks: nothing may move.
    repeat (100) @(negedge clk_i);
    check_now("frozen");
    tick_pulse(1, 2);
    check_now("after_freeze");

`ifdef SENSOR_SKIP_EN
    tick_pulse(1, 0);
    async_reset("skip_reset");
    senzor_ew_i = 1'b0;
    for (int t = 0; t < 9; t++) tick_pulse(1, 1);
    check_phase("skip_ew", phase_a, 1);
    senzor_ew_i = 1'b1;
    for (int t = 0; t < 8; t++) tick_pulse(1, 1);
    check_phase("serve_ew", phase_a, 4);
`endif

    // Randomized ticks, gaps, held ticks, night and sensor levels.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) mode_noapte_i = ~mode_noapte_i;
      senzor_ew_i = ($urandom_range(0, 3) != 0);
      tick_pulse(($urandom_range(0, 7) == 0) ? $urandom_range(2, 3) : 1, $urandom_range(0, 4));
    end
    mode_noapte_i = 1'b0;

    repeat (4) @(negedge clk_i);
    check_now("final");
    checks++;
    if (due_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d ticks without enable, want 0", due_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intersection_phase_seq.md
Name: intersection_phase_seq

Overview:
- Phase sequencer for a two-axis intersection: North-South (NS) and East-West (EW).
- Times each phase by counting a slow tick strobe and produces the 2-bit light codes and transit (yellow-override) flags for each per-direction light decoder.
- Sits directly upstream of the per-direction decoders. w_ns_o drives the N and S decoders' w input, and tranzit_ns_o their tranzit input; the EW outputs do the same for E and W.
- enable_o drives every decoder's enable input.

Parameters:
- T_GREEN, 5, green duration in ticks (1..255)
- T_YELLOW, 2, yellow duration in ticks (1..255)
- T_ALLRED, 1, all-red clearance duration in ticks (1..255)

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low
- tick_i  in  1  one-cycle timing strobe (e.g. 1 Hz); all timing counts these
- mode_noapte_i  in  1  night mode request (level)
- w_ns_o  out  2  NS light code: 00 red, 01 yellow, 10 green, 11 all-red
- w_ew_o  out  2  EW light code, same encoding
- tranzit_ns_o  out  1  forces NS decoders to yellow
- tranzit_ew_o  out  1  forces EW decoders to yellow
- enable_o  out  1  decoder update strobe
- phase_o  out  3  current state encoding, for debug and monitoring

Behaviour:
- Reset. Asynchronous on rst_n_i low, including mid-phase:
  - state=INIT_RED, cnt=0, enable_o=0
  - w_ns_o=w_ew_o=11, tranzit_*=0
- States and phase_o encoding:
  - INIT_RED 0, NS_GREEN 1, NS_YELLOW 2, CLR_1 3, EW_GREEN 4, EW_YELLOW 5, CLR_2 6, NIGHT 7
- Light codes per state (NS/EW):
  - INIT_RED, CLR_1, CLR_2: 11/11
  - NS_GREEN: 10/00
  - NS_YELLOW: 01/00
  - EW_GREEN: 00/10
  - EW_YELLOW: 00/01
  - NIGHT: 11/11 with tranzit_ns_o=tranzit_ew_o=1
- tranzit_* are 0 in every state except NIGHT.
- Outputs are a Moore decode of the state register. They change on the same clk edge as the state update.
- Timer:
  - 8-bit cnt advances only on clk edges where tick_i=1.
  - On a tick with cnt==T_state-1: advance state, cnt<=0. Otherwise cnt<=cnt+1.
  - Each state therefore lasts exactly T_state ticks.
  - INIT_RED, CLR_1 and CLR_2 use T_ALLRED.
- Normal cycle: INIT_RED -> NS_GREEN -> NS_YELLOW -> CLR_1 -> EW_GREEN -> EW_YELLOW -> CLR_2 -> NS_GREEN, repeating.
- Green never goes directly to red; yellow always precedes all-red clearance.
- Night entry:
  - mode_noapte_i is sampled only on ticks.
  - Green states: if it is 1 on a tick, the block moves to that direction's yellow (cnt=0), ignoring the remaining green time. From there the normal yellow -> clearance timing applies.
  - Clearance states (CLR_1, CLR_2, INIT_RED): if it is 1 at expiry, the next state is NIGHT instead of the next green.
  - Yellow states: the yellow always completes.
- NIGHT: stays while mode_noapte_i=1; cnt is held at 0. On the first tick with mode_noapte_i=0, go to INIT_RED (cnt=0), then resume at NS_GREEN.
- Simultaneous events: a night request on the same tick as a timer expiry follows the rules above. Night takes priority over the green -> yellow timer path (the result is the same state, with cnt=0).
- enable_o: registered copy of tick_i, i.e. a 1-cycle pulse one clk after each tick. Decoders therefore sample settled codes once per tick.
- tick_i held high for several cycles counts as that many ticks; no edge detection.

Optional Feature:
- Macro: SENSOR_SKIP_EN
- When defined, adds input senzor_ew_i (1 bit, level, vehicle present on EW).
  - At CLR_1 expiry with senzor_ew_i=0 and no night request, the next state is NS_GREEN instead of EW_GREEN; the EW phase is skipped.
  - A skip restarts the full T_GREEN.
- When not defined, the port is absent and the EW phase is always served.

Test Plan:
- Reset, then tick every 4 clk: INIT_RED for 1 tick -> NS_GREEN for 5 ticks (w_ns_o=10, w_ew_o=00) -> NS_YELLOW for 2 ticks -> CLR_1 for 1 tick (11/11) -> EW_GREEN for 5 ticks -> EW_YELLOW for 2 ticks -> CLR_2 for 1 tick. Check phase_o 0,1,2,3,4,5,6,1 and enable_o pulsing 1 clk after each tick.
- mode_noapte_i=1 on the 2nd tick of NS_GREEN: NS_YELLOW for 2 ticks, then CLR_1 for 1 tick, then NIGHT with tranzit_ns_o=tranzit_ew_o=1. Drop the request: the next tick gives INIT_RED, and the following tick NS_GREEN.
- rst_n_i pulsed low mid EW_GREEN, between clk edges: outputs go to 11/11 immediately with enable_o=0. Restart timing from INIT_RED.
- tick_i=0 for 100 clk: state, cnt and outputs are frozen; enable_o stays 0.
- Parameter override T_GREEN=1, T_YELLOW=1, T_ALLRED=1: the block changes state on every tick; full cycle of 6 states in 6 ticks.
- SENSOR_SKIP_EN, senzor_ew_i=0: CLR_1 -> NS_GREEN; set it to 1 and the following cycle serves EW_GREEN.
